// File: rtl/vga_fb_if.sv
// rtl/vga_fb_if.sv - framebuffer scheduler bus: scan-out FIFO, pixel writer and RAM port
interface vga_fb_if #(
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 12
);
    logic              frame_start;
    logic              pix_rd;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              underflow;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;

    modport slave (
        input  frame_start, pix_rd, wr_req, wr_addr, wr_data, mem_rdata,
        output pix_data, pix_valid, underflow, wr_ack, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output frame_start, pix_rd, wr_req, wr_addr, wr_data, mem_rdata,
        input  pix_data, pix_valid, underflow, wr_ack, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_fb_scheduler.sv
// rtl/vga_fb_scheduler.sv - single-port framebuffer arbiter, scan-out prefetch over pixel writer
module vga_fb_scheduler #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 600,
    parameter int ADDR_W     = 19,
    parameter int PIX_W      = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 4
) (
    input  logic    MAX10_CLK1_50,
    input  logic    RESET_N,
    vga_fb_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [ADDR_W:0]   PIXELS    = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [PIX_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic              re_q, ret_q, ret_live_q;
    logic              uf_q, uf_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [OCC_W-1:0]  occ;
    logic              grant_fetch, grant_wr, push, pop, flush;

    // Occupancy counts reads still in the RAM pipeline, including ones a flush has orphaned.
    assign occ   = OCC_W'(level_q) + OCC_W'(re_q) + OCC_W'(ret_q);
    assign flush = bus.frame_start;
    assign push  = ret_q & ret_live_q & ~flush;
    assign pop   = bus.pix_rd & (level_q != '0);

    always_comb begin
        grant_fetch = 1'b0;
        grant_wr    = 1'b0;
        state_d     = state_q;
        if (state_q == RUN && !flush) begin
            if (occ < OCC_W'(LOW_WATER))       grant_fetch = 1'b1;
            else if (bus.wr_req)               grant_wr    = 1'b1;
            else if (occ < OCC_W'(FIFO_DEPTH)) grant_fetch = 1'b1;
        end else begin
            grant_wr = bus.wr_req;
        end
        case (state_q)
            IDLE, DONE: if (flush) state_d = RUN;
            RUN:        if (grant_fetch && fetch_addr_q == LAST_ADDR) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        level_d      = level_q;
        if (flush) begin
            fetch_addr_d = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            level_d      = '0;
        end else begin
            if (grant_fetch) fetch_addr_d = fetch_addr_q + ADDR_W'(1);
            if (pop)         rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            if (push)        wr_ptr_d     = wr_ptr_q + PTR_W'(1);
            level_d = level_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
        uf_d        = uf_q | (bus.pix_rd & (level_q == '0));
        // Out-of-range writes are acknowledged but never reach the RAM.
        mem_we_d    = grant_wr && ({1'b0, bus.wr_addr} < PIXELS);
        mem_addr_d  = grant_fetch ? fetch_addr_q : (mem_we_d ? bus.wr_addr : '0);
        mem_wdata_d = mem_we_d ? bus.wr_data : '0;
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            re_q         <= 1'b0;
            ret_q        <= 1'b0;
            ret_live_q   <= 1'b0;
            uf_q         <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            re_q         <= grant_fetch;
            ret_q        <= re_q;
            ret_live_q   <= re_q & ~flush;
            uf_q         <= uf_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.mem_rdata;
    end

    assign bus.pix_data  = (level_q != '0) ? fifo_mem[rd_ptr_q] : '0;
    assign bus.pix_valid = (level_q != '0);
    assign bus.underflow = uf_q;
    assign bus.wr_ack    = grant_wr;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_re    = re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb/tb_vga_fb_scheduler.sv - queue-based reference model bench for vga_fb_scheduler
module tb_vga_fb_scheduler;
    localparam int H = 16, V = 8, AW = 8, PW = 12, DEPTH = 16, LOW = 4;
    localparam int TOTAL = H * V;

    typedef struct {
        int             due;
        logic [PW-1:0]  data;
        bit             live;
    } rd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_fb_if #(.ADDR_W(AW), .PIX_W(PW)) bus();

    vga_fb_scheduler #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .PIX_W(PW),
        .FIFO_DEPTH(DEPTH), .LOW_WATER(LOW)
    ) dut (
        .MAX10_CLK1_50(clk),
        .RESET_N(rst_n),
        .bus(bus)
    );

    function automatic logic [PW-1:0] init_pat(input int i);
        return PW'((i * 157) ^ 'h5a3);
    endfunction

    logic [PW-1:0] ram [0:(1<<AW)-1];
    bit ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= init_pat(i);
            ram_loaded <= 1'b1;
        end else begin
            if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    int            n_vec, n_err, cyc, re_seen, last_g, iter;
    int            m_mode, m_next;
    bit            m_uf;
    logic [PW-1:0] m_fb [0:(1<<AW)-1];
    logic [PW-1:0] m_fifo [$];
    rd_t           m_pipe [$];
    bit            e_re, e_we;
    logic [AW-1:0] e_addr;
    logic [PW-1:0] e_wdata;
    bit            w_req;
    logic [AW-1:0] w_addr;
    logic [PW-1:0] w_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_next = 0; m_uf = 1'b0;
        m_fifo.delete(); m_pipe.delete();
        e_re = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    endtask

    // 0 = no grant, 1 = fetch, 2 = write
    function automatic int decide();
        int occ;
        occ = m_fifo.size() + m_pipe.size();
        if (m_mode == 1 && !bus.frame_start) begin
            if (occ < LOW) return 1;
            if (bus.wr_req) return 2;
            if (occ < DEPTH) return 1;
            return 0;
        end
        return bus.wr_req ? 2 : 0;
    endfunction

    task automatic check_cycle();
        chk("wr_ack", bus.wr_ack, decide() == 2);
        chk("pix_valid", bus.pix_valid, m_fifo.size() > 0);
        chk("pix_data", bus.pix_data, (m_fifo.size() > 0) ? m_fifo[0] : 0);
        chk("underflow", bus.underflow, m_uf);
        chk("mem_re", bus.mem_re, e_re);
        chk("mem_we", bus.mem_we, e_we);
        if (e_re || e_we) chk("mem_addr", bus.mem_addr, e_addr);
        if (e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
        if (bus.mem_re) re_seen++;
    endtask

    task automatic update(input int g, input bit fs, input bit rd,
                          input logic [AW-1:0] wa, input logic [PW-1:0] wd);
        rd_t r;
        e_re = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        if (g == 2 && wa < TOTAL) begin
            e_we = 1'b1; e_addr = wa; e_wdata = wd; m_fb[wa] = wd;
        end
        if (g == 1) begin
            r.due = cyc + 2; r.data = m_fb[m_next]; r.live = 1'b1;
            m_pipe.push_back(r);
            e_re = 1'b1; e_addr = AW'(m_next);
            if (m_next == TOTAL - 1) m_mode = 2;
            m_next++;
        end
        if (rd) begin
            if (m_fifo.size() > 0) void'(m_fifo.pop_front());
            else m_uf = 1'b1;
        end
        while (m_pipe.size() > 0 && m_pipe[0].due == cyc) begin
            r = m_pipe.pop_front();
            if (r.live && !fs) m_fifo.push_back(r.data);
        end
        if (fs) begin
            m_fifo.delete();
            foreach (m_pipe[i]) m_pipe[i].live = 1'b0;
            m_next = 0; m_mode = 1;
        end
        last_g = g;
        cyc++;
    endtask

    task automatic drive(input bit fs, input bit rd);
        bus.frame_start = fs; bus.pix_rd = rd;
        bus.wr_req = w_req; bus.wr_addr = w_addr; bus.wr_data = w_data;
    endtask

    task automatic tick();
        int g;
        @(negedge clk);
        check_cycle();
        g = decide();
        @(posedge clk);
        update(g, bus.frame_start, bus.pix_rd, bus.wr_addr, bus.wr_data);
        #1;
    endtask

    task automatic new_wr();
        w_req = 1'b1;
        w_addr = AW'($urandom_range(0, TOTAL + 15));
        w_data = PW'($urandom);
    endtask

    task automatic do_reset();
        w_req = 1'b0;
        drive(1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pix_valid", bus.pix_valid, 0);
        chk("rst_pix_data", bus.pix_data, 0);
        chk("rst_underflow", bus.underflow, 0);
        chk("rst_wr_ack", bus.wr_ack, 0);
        chk("rst_mem_re", bus.mem_re, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; re_seen = 0; last_g = 0;
        w_req = 1'b0; w_addr = '0; w_data = '0;
        for (int i = 0; i < (1 << AW); i++) m_fb[i] = init_pat(i);
        model_reset();
        drive(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_cycle();
        rst_n = 1'b1;
        repeat (4) begin drive(1'b0, 1'b0); tick(); end

        // fill with no consumer and no writer
        re_seen = 0;
        drive(1'b1, 1'b0); tick();
        repeat (24) begin drive(1'b0, 1'b0); tick(); end
        chk("fill_re_cnt", re_seen, 16);
        chk("fill_valid", bus.pix_valid, 1);

        // reset in the middle of a frame
        drive(1'b1, 1'b0); tick();
        drive(1'b0, 1'b0); tick(); tick();
        do_reset();
        repeat (5) begin drive(1'b0, 1'b0); tick(); end
        chk("post_rst_valid", bus.pix_valid, 0);

        // writer holds requests while scan-out drains every cycle
        drive(1'b1, 1'b0); tick();
        repeat (20) begin drive(1'b0, 1'b0); tick(); end
        new_wr();
        iter = 0;
        while (m_mode == 1 && iter < 2000) begin
            drive(1'b0, 1'b1); tick();
            if (last_g == 2) new_wr();
            iter++;
        end
        n_vec++;
        assert (iter < 2000) else begin
            n_err++;
            $error("FAIL prio_timeout: cycles %0d limit 2000", iter);
        end
        chk("prio_uf", bus.underflow, 0);
        repeat (30) begin
            drive(1'b0, m_fifo.size() > 0); tick();
            if (last_g == 2) new_wr();
        end

        // out-of-range write is acked but dropped
        w_req = 1'b1; w_addr = AW'(TOTAL); w_data = 12'habc;
        drive(1'b0, 1'b0); tick();
        chk("oor_ack", last_g, 2);
        chk("oor_we", bus.mem_we, 0);
        w_req = 1'b0;
        drive(1'b0, 1'b0); tick();
        chk("oor_ram", ram[TOTAL], init_pat(TOTAL));

        // randomized traffic with occasional frame restarts
        drive(1'b1, 1'b0); tick();
        repeat (600) begin
            if (!w_req && $urandom_range(0, 2) == 0) new_wr();
            drive($urandom_range(0, 79) == 0, m_fifo.size() > 0 && $urandom_range(0, 3) != 0);
            tick();
            if (last_g == 2) w_req = 1'b0;
        end

        // restart with two reads in flight
        w_req = 1'b0;
        drive(1'b1, 1'b0); tick();
        repeat (30) begin drive(1'b0, 1'b0); tick(); end
        drive(1'b1, 1'b0); tick();
        drive(1'b0, 1'b0); tick(); tick();
        drive(1'b1, 1'b0); tick();
        repeat (10) begin drive(1'b0, 1'b0); tick(); end
        chk("flush_head", bus.pix_data, m_fb[0]);

        // underflow is sticky until reset
        do_reset();
        drive(1'b1, 1'b0); tick();
        drive(1'b0, 1'b0); tick();
        drive(1'b0, 1'b1); tick();
        chk("uf_set", bus.underflow, 1);
        repeat (20) begin drive(1'b0, m_fifo.size() > 0); tick(); end
        chk("uf_sticky", bus.underflow, 1);
        do_reset();
        repeat (3) begin drive(1'b0, 1'b0); tick(); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
